// File: rtl/redir_ctrl_pkg.sv
// Shared types and constants for the redirect controller.
package redir_ctrl_pkg;

    localparam int CPU_WIDTH = 64;

    // FSM encoding kept as plain constants for legacy tool flows
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_FLUSH_IC = 2'd2;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BRU,
        SRC_FENCEI,
        SRC_TRAP
    } redir_src_e;

    // Oldest instruction wins: trap (commit) > fence.i (commit) > branch (ID)
    function automatic redir_src_e pick_src(input logic trap, input logic fencei,
                                            input logic bru);
        if (trap)        return SRC_TRAP;
        else if (fencei) return SRC_FENCEI;
        else if (bru)    return SRC_BRU;
        else             return SRC_NONE;
    endfunction

endpackage

// File: rtl/redir_ctrl_if.sv
// Redirect request/response bundle between redirect sources, IFU, I-cache
// and the controller. Perf counter outputs exist only with REDIR_CTRL_PERF_EN.
interface redir_ctrl_if;
    logic                                i_bru_req;
    logic [redir_ctrl_pkg::CPU_WIDTH-1:0] i_bru_pc;
    logic                                i_trap_req;
    logic [redir_ctrl_pkg::CPU_WIDTH-1:0] i_trap_pc;
    logic                                i_fencei_req;
    logic [redir_ctrl_pkg::CPU_WIDTH-1:0] i_fencei_pc;
    logic                                i_ifu_ready;
    logic                                i_icache_flush_done;
    logic                                o_redir_valid;
    logic [redir_ctrl_pkg::CPU_WIDTH-1:0] o_redir_pc;
    logic                                o_flush_ifid;
    logic                                o_flush_idex;
    logic                                o_icache_flush_req;
    logic                                o_busy;
`ifdef REDIR_CTRL_PERF_EN
    logic [31:0]                         o_perf_bru_cnt;
    logic [31:0]                         o_perf_trap_cnt;
    logic [31:0]                         o_perf_stall_cnt;
`endif

    // controller side
    modport master (
        input  i_bru_req, i_bru_pc, i_trap_req, i_trap_pc, i_fencei_req,
               i_fencei_pc, i_ifu_ready, i_icache_flush_done,
`ifdef REDIR_CTRL_PERF_EN
        output o_perf_bru_cnt, o_perf_trap_cnt, o_perf_stall_cnt,
`endif
        output o_redir_valid, o_redir_pc, o_flush_ifid, o_flush_idex,
               o_icache_flush_req, o_busy
    );

    // pipeline / IFU side
    modport slave (
        output i_bru_req, i_bru_pc, i_trap_req, i_trap_pc, i_fencei_req,
               i_fencei_pc, i_ifu_ready, i_icache_flush_done,
`ifdef REDIR_CTRL_PERF_EN
        input  o_perf_bru_cnt, o_perf_trap_cnt, o_perf_stall_cnt,
`endif
        input  o_redir_valid, o_redir_pc, o_flush_ifid, o_flush_idex,
               o_icache_flush_req, o_busy
    );
endinterface

// File: rtl/redir_ctrl_perf_cnt.sv
// One saturating 32-bit event counter (used only with REDIR_CTRL_PERF_EN).
module redir_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);
    // count events, stick at all-ones
    always_ff @(posedge clk) begin
        if (rst)                              cnt <= '0;
        else if (inc && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
    end
endmodule

// File: rtl/redir_ctrl.sv
// Redirect controller: arbitrates trap / fence.i / branch redirects into the
// fetch stage, holds the winner until IFU accepts, sequences the I-cache
// flush for fence.i, and drives pipeline flushes and the decode stall.
// Optional perf counters: define REDIR_CTRL_PERF_EN.
module redir_ctrl
    import redir_ctrl_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    redir_ctrl_if.master bus
);
    localparam logic [CPU_WIDTH-1:0] PC_MASK = {{(CPU_WIDTH-1){1'b1}}, 1'b0};

    logic [1:0]           state, nxt_state;
    logic [CPU_WIDTH-1:0] pend_pc, ld_pc, win_pc, pc_raw;
    logic                 ld;
    redir_src_e           win_src;

    // arbitration among the raw requests
    always_comb begin
        win_src = pick_src(bus.i_trap_req, bus.i_fencei_req, bus.i_bru_req);
        case (win_src)
            SRC_TRAP:   win_pc = bus.i_trap_pc;
            SRC_FENCEI: win_pc = bus.i_fencei_pc;
            default:    win_pc = bus.i_bru_pc;
        endcase
    end

    // next-state and output decode; everything quiet while in reset
    always_comb begin
        nxt_state              = state;
        ld                     = 1'b0;
        ld_pc                  = bus.i_trap_pc;
        pc_raw                 = pend_pc;
        bus.o_redir_valid      = 1'b0;
        bus.o_flush_ifid       = 1'b0;
        bus.o_flush_idex       = 1'b0;
        bus.o_icache_flush_req = 1'b0;
        bus.o_busy             = 1'b0;
        if (!i_rst) begin
            case (state)
                ST_IDLE: begin
                    if (win_src == SRC_FENCEI) begin
                        // refetch only after the I-cache is clean
                        bus.o_flush_ifid = 1'b1;
                        bus.o_flush_idex = 1'b1;
                        bus.o_busy       = 1'b1;
                        ld               = 1'b1;
                        ld_pc            = bus.i_fencei_pc;
                        nxt_state        = ST_FLUSH_IC;
                    end else if (win_src != SRC_NONE) begin
                        bus.o_redir_valid = 1'b1;
                        pc_raw            = win_pc;
                        bus.o_flush_ifid  = 1'b1;
                        bus.o_flush_idex  = (win_src == SRC_TRAP);
                        if (!bus.i_ifu_ready) begin
                            bus.o_busy = 1'b1;
                            ld         = 1'b1;
                            ld_pc      = win_pc;
                            nxt_state  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    bus.o_redir_valid = 1'b1;
                    bus.o_busy        = 1'b1;
                    if (bus.i_trap_req) begin
                        // a trap is older than anything pending; take it over
                        bus.o_flush_ifid = 1'b1;
                        bus.o_flush_idex = 1'b1;
                        ld               = 1'b1;
                        if (bus.i_ifu_ready) pc_raw = bus.i_trap_pc;
                    end
                    if (bus.i_ifu_ready) nxt_state = ST_IDLE;
                end
                ST_FLUSH_IC: begin
                    bus.o_icache_flush_req = 1'b1;
                    bus.o_busy             = 1'b1;
                    if (bus.i_trap_req) begin
                        // retarget but let the cache flush run to completion
                        bus.o_flush_ifid = 1'b1;
                        bus.o_flush_idex = 1'b1;
                        ld               = 1'b1;
                    end
                    if (bus.i_icache_flush_done) nxt_state = ST_HOLD;
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
        bus.o_redir_pc = bus.o_redir_valid ? (pc_raw & PC_MASK) : '0;
    end

    // state and pending-target registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            pend_pc <= '0;
        end else begin
            state <= nxt_state;
            if (ld) pend_pc <= ld_pc;
        end
    end

`ifdef REDIR_CTRL_PERF_EN
    redir_src_e pend_src, cur_src;
    logic       accept;

    // source of whatever is currently being offered to IFU
    always_comb begin
        cur_src = win_src;
        if (state == ST_HOLD) cur_src = bus.i_trap_req ? SRC_TRAP : pend_src;
        accept = bus.o_redir_valid && bus.i_ifu_ready;
    end

    // remember which source the pending pc belongs to
    always_ff @(posedge i_clk) begin
        if (i_rst)   pend_src <= SRC_NONE;
        else if (ld) pend_src <= (state == ST_IDLE) ? win_src : SRC_TRAP;
    end

    redir_perf_cnt u_bru_cnt (
        .clk(i_clk), .rst(i_rst), .inc(accept && cur_src == SRC_BRU),
        .cnt(bus.o_perf_bru_cnt)
    );
    redir_perf_cnt u_trap_cnt (
        .clk(i_clk), .rst(i_rst), .inc(accept && cur_src == SRC_TRAP),
        .cnt(bus.o_perf_trap_cnt)
    );
    redir_perf_cnt u_stall_cnt (
        .clk(i_clk), .rst(i_rst), .inc(bus.o_busy),
        .cnt(bus.o_perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_redir_ctrl.sv
// Directed scoreboard bench for redir_ctrl: each step pushes the expected
// output vector, then pops and compares it mid-cycle.
module tb_redir_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    redir_ctrl_if bus ();
    redir_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        fi;
        logic        fx;
        logic        icf;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_stall = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drv(input logic bru, input logic [63:0] bpc, input logic trap,
                       input logic [63:0] tpc, input logic fen, input logic [63:0] fpc,
                       input logic rdy, input logic done);
        bus.i_bru_req = bru;   bus.i_bru_pc = bpc;
        bus.i_trap_req = trap; bus.i_trap_pc = tpc;
        bus.i_fencei_req = fen; bus.i_fencei_pc = fpc;
        bus.i_ifu_ready = rdy; bus.i_icache_flush_done = done;
    endtask

    task automatic idle_in();
        drv(0, 64'h0, 0, 64'h0, 0, 64'h0, 0, 0);
    endtask

    // push expectation, compare at negedge, advance to just past the next posedge
    task automatic step(input string tag, input logic v, input logic [63:0] pc,
                        input logic fi, input logic fx, input logic icf, input logic busy);
        exp_t e;
        e = '{v: v, pc: pc, fi: fi, fx: fx, icf: icf, busy: busy};
        sb.push_back(e);
        if (busy && !rst) exp_stall++;
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".valid"}, {63'b0, bus.o_redir_valid}, {63'b0, e.v});
        chk({tag, ".pc"}, bus.o_redir_pc, e.pc);
        chk({tag, ".flush_ifid"}, {63'b0, bus.o_flush_ifid}, {63'b0, e.fi});
        chk({tag, ".flush_idex"}, {63'b0, bus.o_flush_idex}, {63'b0, e.fx});
        chk({tag, ".icache_flush"}, {63'b0, bus.o_icache_flush_req}, {63'b0, e.icf});
        chk({tag, ".busy"}, {63'b0, bus.o_busy}, {63'b0, e.busy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        // reset: outputs silent even with a request present
        step("rst0", 0, 0, 0, 0, 0, 0);
        drv(1, 64'h40, 0, 0, 0, 0, 1, 0);
        step("rst1", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle_in();
        step("idle", 0, 0, 0, 0, 0, 0);

        // zero-latency branch redirect, bit0 cleared
        drv(1, 64'h8000_0101, 0, 0, 0, 0, 1, 0);
        step("bru_fast", 1, 64'h8000_0100, 1, 0, 0, 0);
        // trap beats branch
        drv(1, 64'h8000_0200, 1, 64'h8000_0004, 0, 0, 1, 0);
        step("trap_prio", 1, 64'h8000_0004, 1, 1, 0, 0);
        // bit1 passes through
        drv(1, 64'h8003, 0, 0, 0, 0, 1, 0);
        step("bit1", 1, 64'h8002, 1, 0, 0, 0);

        // held branch, new branch ignored in HOLD
        drv(1, 64'h200, 0, 0, 0, 0, 0, 0);
        step("hold0", 1, 64'h200, 1, 0, 0, 1);
        drv(1, 64'h300, 0, 0, 0, 0, 0, 0);
        step("hold1", 1, 64'h200, 0, 0, 0, 1);
        idle_in();
        step("hold2", 1, 64'h200, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        step("hold3", 1, 64'h200, 0, 0, 0, 1);
        idle_in();
        step("hold_done", 0, 0, 0, 0, 0, 0);

        // trap replaces pending target in HOLD
        drv(1, 64'h200, 0, 0, 0, 0, 0, 0);
        step("hrep0", 1, 64'h200, 1, 0, 0, 1);
        drv(0, 0, 1, 64'h100, 0, 0, 0, 0);
        step("hrep1", 1, 64'h200, 1, 1, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        step("hrep2", 1, 64'h100, 0, 0, 0, 1);
        idle_in();
        step("hrep_done", 0, 0, 0, 0, 0, 0);

        // trap with ifu_ready in HOLD is driven straight through
        drv(1, 64'h400, 0, 0, 0, 0, 0, 0);
        step("htr0", 1, 64'h400, 1, 0, 0, 1);
        drv(0, 0, 1, 64'h500, 0, 0, 1, 0);
        step("htr1", 1, 64'h500, 1, 1, 0, 1);
        idle_in();
        step("htr_done", 0, 0, 0, 0, 0, 0);

        // flush_done outside FLUSH_IC does nothing
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        step("stray_done", 0, 0, 0, 0, 0, 0);

        // fence.i beats branch, even with ifu_ready
        drv(1, 64'h600, 0, 0, 1, 64'h1004, 1, 0);
        step("fen0", 0, 0, 1, 1, 0, 1);
        idle_in();
        for (int i = 0; i < 4; i++) step("fen_wait", 0, 0, 0, 0, 1, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        step("fen_done", 0, 0, 0, 0, 1, 1);
        idle_in();
        step("fen_hold", 1, 64'h1004, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        step("fen_acc", 1, 64'h1004, 0, 0, 0, 1);
        idle_in();
        step("fen_idle", 0, 0, 0, 0, 0, 0);

        // trap during cache flush retargets, flush still completes
        drv(0, 0, 0, 0, 1, 64'h2000, 0, 0);
        step("ftr0", 0, 0, 1, 1, 0, 1);
        drv(0, 0, 1, 64'h3000, 0, 0, 0, 0);
        step("ftr1", 0, 0, 1, 1, 1, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        step("ftr2", 0, 0, 0, 0, 1, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        step("ftr3", 1, 64'h3000, 0, 0, 0, 1);
        idle_in();
        step("ftr_idle", 0, 0, 0, 0, 0, 0);

`ifdef REDIR_CTRL_PERF_EN
        @(negedge clk);
        chk("perf_bru", {32'b0, bus.o_perf_bru_cnt}, 64'd3);
        chk("perf_trap", {32'b0, bus.o_perf_trap_cnt}, 64'd4);
        chk("perf_stall", {32'b0, bus.o_perf_stall_cnt}, 64'(exp_stall));
        @(posedge clk);
        #1;
`endif

        // reset in the middle of a cache flush
        drv(0, 0, 0, 0, 1, 64'h1004, 0, 0);
        step("rfl0", 0, 0, 1, 1, 0, 1);
        idle_in();
        step("rfl1", 0, 0, 0, 0, 1, 1);
        rst = 1'b1;
        step("rfl_rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("rfl_after", 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 1);
        step("rfl_idle", 0, 0, 0, 0, 0, 0);

`ifdef REDIR_CTRL_PERF_EN
        @(negedge clk);
        chk("perf_bru_rst", {32'b0, bus.o_perf_bru_cnt}, 64'd0);
        chk("perf_trap_rst", {32'b0, bus.o_perf_trap_cnt}, 64'd0);
        chk("perf_stall_rst", {32'b0, bus.o_perf_stall_cnt}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/redir_ctrl.md
Name: redir_ctrl

Overview:
- Arbitrates and sequences every change of control flow into the fetch stage.
- Redirect sources: branch unit (ID-stage branch/jal/jalr), commit-stage trap/mret, and fence.i (needs an I-cache flush before refetch).
- Selects one winner and holds it until IFU accepts it.
- Drives the IF/ID and ID/EX flushes and stalls the decode stage while a redirect is outstanding.

Parameters:
- CPU_WIDTH, 64, width of PC/address.
- Reset of internal pc register is 0.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_bru_req  in  1  branch unit requests redirect (taken branch/jal/jalr).
- i_bru_pc  in  CPU_WIDTH  branch unit target.
- i_trap_req  in  1  commit-stage trap/mret redirect.
- i_trap_pc  in  CPU_WIDTH  trap vector / mepc.
- i_fencei_req  in  1  fence.i committed.
- i_fencei_pc  in  CPU_WIDTH  fence.i pc+4.
- i_ifu_ready  in  1  IFU accepts redirect this cycle.
- i_icache_flush_done  in  1  one-cycle pulse, I-cache invalidate complete.
- o_redir_valid  out  1  redirect presented to IFU.
- o_redir_pc  out  CPU_WIDTH  redirect target, bit0 forced 0.
- o_flush_ifid  out  1  kill IF/ID register.
- o_flush_idex  out  1  kill ID/EX register.
- o_icache_flush_req  out  1  level request to I-cache.
- o_busy  out  1  stall IDU; new branch redirects not accepted.

Behaviour:
- Reset: state=IDLE, pending pc=0, all outputs 0.
- Priority (oldest instruction wins): trap > fence.i > bru.
- States: IDLE, HOLD, FLUSH_IC.
- IDLE, winner present, i_ifu_ready=1:
  - o_redir_valid=1 and o_redir_pc=winner pc combinationally, same cycle (zero latency).
  - Stay IDLE.
- IDLE, winner present, i_ifu_ready=0:
  - Register winner pc.
  - o_redir_valid=1 with the combinational pc this cycle.
  - Next state HOLD.
- IDLE, fence.i winner (overrides the two IDLE rules above):
  - No redirect this cycle.
  - Register i_fencei_pc; next state FLUSH_IC.
- Flushes, bru winner: o_flush_ifid=1 in the accept cycle.
- Flushes, trap or fence.i winner: o_flush_ifid=1 and o_flush_idex=1 in the accept cycle.
- Flushes are single-cycle, asserted in the cycle the request is taken, not repeated in HOLD.
- HOLD:
  - o_redir_valid=1, o_redir_pc=registered pc, o_busy=1.
  - On i_ifu_ready=1, go IDLE the next cycle.
  - i_bru_req ignored.
  - i_trap_req replaces the pending pc and pulses both flushes. If i_ifu_ready=1 in the same cycle, the trap pc is driven combinationally and the state goes IDLE.
- FLUSH_IC:
  - o_icache_flush_req=1, o_busy=1, o_redir_valid=0.
  - i_trap_req during FLUSH_IC overwrites the pending pc and pulses both flushes; the cache flush is never aborted.
  - On i_icache_flush_done, deassert the request next cycle and go HOLD. The redirect is then issued by the HOLD rules.
- o_busy=1 in the IDLE cycle a non-accepted or fence.i request is taken, and in every HOLD/FLUSH_IC cycle.
- o_redir_pc[0] is always 0 (jalr rule); bit1 is passed through unchanged (misalignment is handled by the trap path).
- i_icache_flush_done outside FLUSH_IC is ignored.
- Reset mid-HOLD/FLUSH_IC: return to IDLE next edge, pending request dropped, o_icache_flush_req deasserted.

Optional Feature:
- Macro REDIR_CTRL_PERF_EN.
- Defined: adds outputs o_perf_bru_cnt, o_perf_trap_cnt, o_perf_stall_cnt (32 bits each).
  - bru/trap counters increment once per accepted redirect of that source.
  - stall counter increments on every o_busy cycle.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package (config.sv): redir_state_e {IDLE, HOLD, FLUSH_IC}; redir_src_e {SRC_NONE, SRC_BRU, SRC_FENCEI, SRC_TRAP}.
- Pending pc register uses existing stl_reg.
- One sub-module, redir_perf_cnt (one saturating counter, instantiated 3x), exists only under REDIR_CTRL_PERF_EN.

Test Plan:
- bru_req=1, bru_pc=0x8000_0101, ifu_ready=1 -> same cycle: redir_valid=1, redir_pc=0x8000_0100, flush_ifid=1, flush_idex=0, busy=0.
- bru_req and trap_req together, trap_pc=0x8000_0004, ifu_ready=1 -> redir_pc=0x8000_0004, both flushes=1.
- bru_req, pc 0x200, ifu_ready=0 for 3 cycles -> redir_valid and busy high 4 cycles, pc 0x200; single flush pulse; new bru_req=0x300 in HOLD ignored.
- HOLD on 0x200, trap_req pc=0x100 -> pending becomes 0x100, both flushes pulse; redirect 0x100 on ifu_ready.
- fencei_req, pc=0x1004 -> icache_flush_req high until flush_done pulse 5 cycles later, then redir_valid with 0x1004; no redirect before done.
- i_rst=1 during FLUSH_IC -> next cycle all outputs 0, state IDLE; perf counters 0 when REDIR_CTRL_PERF_EN is set.
